// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch unit: word width, reset PC
// default, the NOP word, FSM state encoding, the buffer entry layout and a
// small PC alignment helper.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int WORD_W  = 32;
  localparam int ENTRY_W = 2 * WORD_W;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [WORD_W-1:0] NOP              = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_STEP          = 32'd4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_MISS = 1'b1
  } fetch_state_e;

  // One buffered fetch: address in the upper word, instruction in the lower.
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the fetch unit's icache, redirect, decode and status signals.
//   master : the fetch unit (drives icache_addr, instr, instr_pc, valid,
//            miss_cycles; receives icache_data/hit, branch, stall)
//   slave  : the environment (icache + downstream pipeline)
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic [WORD_W-1:0] icache_addr;
  logic [WORD_W-1:0] icache_data;
  logic              icache_hit;
  logic              branch_taken;
  logic [WORD_W-1:0] branch_target;
  logic              stall;
  logic [WORD_W-1:0] instr;
  logic [WORD_W-1:0] instr_pc;
  logic              valid;
  logic [WORD_W-1:0] miss_cycles;

  modport master (
    output icache_addr,
    input  icache_data,
    input  icache_hit,
    input  branch_taken,
    input  branch_target,
    input  stall,
    output instr,
    output instr_pc,
    output valid,
    output miss_cycles
  );

  modport slave (
    input  icache_addr,
    output icache_data,
    output icache_hit,
    output branch_taken,
    output branch_target,
    output stall,
    input  instr,
    input  instr_pc,
    input  valid,
    input  miss_cycles
  );

endinterface

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Small circular FIFO holding fetched {pc, instr} entries.
//   clk, reset  : clock, synchronous active-low reset
//   push        : write wr_data (accepted when not full, or full with a pop)
//   pop         : retire the head entry (ignored when empty)
//   flush       : drop every entry
//   wr_data     : entry to write
//   rd_data     : head entry, all zeros when empty
//   full, empty : occupancy status
// -----------------------------------------------------------------------------
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               full,
  output logic               empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               do_push;
  logic               do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign do_pop  = pop && !empty;
  // A full buffer can still take a write when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_next(rd_ptr_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end: holds the PC, fetches one word per cycle from
// the icache into a small buffer, counts missed fetch attempts and handles
// branch redirects.
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-low
//   bus   : fetch_unit_if.master -- icache_addr/data/hit, branch_taken/target,
//           stall, instr, instr_pc, valid, miss_cycles
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int                BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] miss_q, miss_d;
  fetch_state_e      state_q, state_d;

  logic         running;
  logic         attempt;
  logic         buf_push;
  logic         buf_pop;
  logic         buf_full;
  logic         buf_empty;
  fetch_entry_t wr_entry;
  fetch_entry_t rd_entry;

  assign running  = reset;
  // A branch flushes instead of popping, and suppresses the fetch attempt.
  assign buf_pop  = running && !buf_empty && !bus.stall && !bus.branch_taken;
  assign attempt  = running && !bus.branch_taken && (!buf_full || buf_pop);
  assign buf_push = attempt && bus.icache_hit;
  assign wr_entry = '{pc: pc_q, instr: bus.icache_data};

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .push    (buf_push),
    .pop     (buf_pop),
    .flush   (bus.branch_taken),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .full    (buf_full),
    .empty   (buf_empty)
  );

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    miss_d  = miss_q;
    if (bus.branch_taken) begin
      pc_d    = align_word(bus.branch_target);
      state_d = ST_RUN;
    end else if (attempt) begin
      if (bus.icache_hit) begin
        pc_d    = pc_q + PC_STEP;
        state_d = ST_RUN;
      end else begin
        state_d = ST_MISS;
        if (miss_q != '1) begin
          miss_d = miss_q + WORD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
      miss_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      miss_q  <= miss_d;
    end
  end

  // Outputs are forced to their reset values while reset is held so they are
  // defined even before the first reset edge has been seen.
  assign bus.icache_addr = running ? pc_q : RESET_PC;
  assign bus.valid       = running && !buf_empty;
  assign bus.instr       = bus.valid ? rd_entry.instr : NOP;
  assign bus.instr_pc    = bus.valid ? rd_entry.pc    : NOP;
  assign bus.miss_cycles = miss_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed and randomized stimulus for fetch_unit, checked each cycle against
// a queue-based reference model of the fetch behaviour.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic clk = 1'b0;
  logic reset;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC  (RPC),
    .BUF_DEPTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Icache contents: a fixed, address-dependent word.
  function automatic logic [31:0] icdata(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.icache_data = icdata(bus.icache_addr);

  // Reference model state
  logic [31:0] m_pc      = RPC;
  logic [31:0] m_miss    = 32'h0;
  logic        m_in_miss = 1'b0;
  logic [63:0] m_q[$];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic rn, input logic br, input logic [31:0] tgt,
                      input logic stl, input logic hit, input bit check);
    logic popped;
    logic can;
    logic have;
    reset             = rn;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.stall         = stl;
    bus.icache_hit    = hit;
    #1;
    if (check) begin
      have = rn && (m_q.size() > 0);
      chk("valid",       32'(bus.valid), 32'(have));
      chk("instr",       bus.instr,    have ? m_q[0][31:0]  : 32'h0);
      chk("instr_pc",    bus.instr_pc, have ? m_q[0][63:32] : 32'h0);
      chk("icache_addr", bus.icache_addr, rn ? m_pc : RPC);
      chk("miss_cycles", bus.miss_cycles, m_miss);
      chk("state_miss",  32'(dut.state_q == ST_MISS), 32'(m_in_miss));
    end
    @(posedge clk);
    if (!rn) begin
      m_pc = RPC;
      m_q.delete();
      m_miss = 32'h0;
      m_in_miss = 1'b0;
    end else if (br) begin
      m_q.delete();
      m_pc = tgt & 32'hFFFF_FFFC;
      m_in_miss = 1'b0;
    end else begin
      popped = (m_q.size() > 0) && !stl;
      can    = (m_q.size() < 2) || popped;
      if (popped) void'(m_q.pop_front());
      if (can) begin
        if (hit) begin
          m_q.push_back({m_pc, icdata(m_pc)});
          m_pc = m_pc + 32'd4;
          m_in_miss = 1'b0;
        end else begin
          if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 32'd1;
          m_in_miss = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset             = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.stall         = 1'b0;
    bus.icache_hit    = 1'b1;

    // Reset: first edge unchecked (registers unknown before it), then checked.
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("rst_valid", 32'(bus.valid), 32'h0);
    chk("rst_addr",  bus.icache_addr, RPC);
    chk("rst_miss",  bus.miss_cycles, 32'h0);

    // Sequential fetch after reset release.
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("seq_addr1",  bus.icache_addr, 32'h0040_0004);
    chk("seq_valid1", 32'(bus.valid), 32'h1);
    chk("seq_ipc1",   bus.instr_pc, 32'h0040_0000);
    chk("seq_instr1", bus.instr, icdata(32'h0040_0000));
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("seq_addr2",  bus.icache_addr, 32'h0040_0008);
    chk("seq_ipc2",   bus.instr_pc, 32'h0040_0004);
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

    // Miss run at 00400040.
    tick(1'b1, 1'b1, 32'h0040_0040, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("miss_addr",  bus.icache_addr, 32'h0040_0040);
    chk("miss_cnt",   bus.miss_cycles, 32'd3);
    chk("miss_state", 32'(dut.state_q == ST_MISS), 32'h1);
    chk("miss_empty", 32'(bus.valid), 32'h0);
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("miss_ipc",   bus.instr_pc, 32'h0040_0040);
    chk("miss_run",   32'(dut.state_q == ST_MISS), 32'h0);

    // Backpressure: fill, hold, then drain in order.
    tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("stall_addr", bus.icache_addr, RPC + 32'd8);
    tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("stall_hold", bus.icache_addr, RPC + 32'd8);
    chk("stall_head", bus.instr_pc, RPC);
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("drain_2nd",  bus.instr_pc, RPC + 32'd4);
    chk("drain_miss", bus.miss_cycles, 32'd1);
    tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Branch while full: flush, aligned target, no stale entries.
    tick(1'b1, 1'b1, 32'h0030_E042, 1'b1, 1'b1, 1'b1);
    chk("br_valid", 32'(bus.valid), 32'h0);
    chk("br_addr",  bus.icache_addr, 32'h0030_E040);
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("br_first", bus.instr_pc, 32'h0030_E040);

    // PC wrap, then reset during a miss with a competing branch.
    tick(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("wrap_addr", bus.icache_addr, 32'h0000_0000);
    chk("wrap_ipc",  bus.instr_pc, 32'hFFFF_FFFC);
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("rst_mid_addr", bus.icache_addr, RPC);
    chk("rst_mid_miss", bus.miss_cycles, 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic        r_rn;
      logic        r_br;
      logic [31:0] r_tgt;
      logic        r_st;
      logic        r_hit;
      r_rn  = ($urandom_range(0, 63) != 0);
      r_br  = ($urandom_range(0, 15) == 0);
      r_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      r_st  = ($urandom_range(0, 2) == 0);
      r_hit = ($urandom_range(0, 3) != 0);
      tick(r_rn, r_br, r_tgt, r_st, r_hit, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00400000, is the first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, is the number of entries in the instruction buffer; only 2 is required.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  is the reset; it is synchronous and active-low (0 = reset).
REQ-005 Port icache_addr  output  32  is the fetch address (PC) driven to the icache.
REQ-006 Port icache_data  input  32  is the instruction word from the icache, combinational from icache_addr.
REQ-007 Port icache_hit  input  1  qualifies icache_data in the same cycle.
REQ-008 Port branch_taken  input  1  is the redirect request from downstream.
REQ-009 Port branch_target  input  32  is the redirect address.
REQ-010 Port stall  input  1  is backpressure from decode.
REQ-011 Port instr  output  32  is the head instruction to decode.
REQ-012 Port instr_pc  output  32  is the address of instr.
REQ-013 Port valid  output  1  means instr and instr_pc are meaningful.
REQ-014 Port miss_cycles  output  32  is the count of missed fetch attempts.

Function
REQ-015 The block SHALL keep a PC register and SHALL drive icache_addr = PC continuously.
REQ-016 A fetch attempt SHALL occur in any cycle with reset=1, branch_taken=0 and buffer not full, or full with a pop in the same cycle.
REQ-017 An attempt with icache_hit=1 SHALL push {PC, icache_data} into the buffer and advance PC by 4 at the clock edge (modulo 2^32, wrapping FFFFFFFC -> 00000000).
REQ-018 An attempt with icache_hit=0 SHALL hold PC, push nothing, and increment miss_cycles; miss_cycles saturates at FFFFFFFF.
REQ-019 The FSM SHALL have exactly two states: RUN and MISS.
REQ-020 RUN -> MISS on an attempt with hit=0; MISS -> RUN on an attempt with hit=1; no change when no attempt is made.
REQ-021 branch_taken=1 SHALL override fetch: it flushes the buffer, loads PC with {branch_target[31:2], 2'b00}, sets the state to RUN, and ignores icache_hit that cycle.
REQ-022 valid SHALL equal buffer non-empty; instr and instr_pc SHALL show the oldest entry, or 0 when empty.
REQ-023 The head entry SHALL pop at the edge when valid=1 and stall=0, except on a branch, which flushes instead.
REQ-024 With the buffer full and a pop in the same cycle, a hit attempt SHALL push, keeping occupancy at 2; without a pop, PC and the buffer SHALL hold.
REQ-025 Instruction order SHALL be preserved and no entry SHALL be duplicated or dropped except by a flush.
REQ-026 Hit-path latency SHALL be one cycle: a word fetched at edge N is visible with valid=1 after edge N.

Reset
REQ-027 When reset=0 at an edge: PC=RESET_PC, state=RUN, buffer empty, miss_cycles=0.
REQ-028 During reset the outputs SHALL be valid=0, instr=0, instr_pc=0 and icache_addr=RESET_PC.
REQ-029 Reset asserted mid-miss or with a full buffer SHALL discard all state and take priority over branch_taken.

Structure
REQ-030 A shared package SHALL hold RESET_PC default, the FSM state encoding (RUN, MISS), the word width 32, and the NOP constant 0.
REQ-031 The buffer SHALL be a sub-module fetch_buffer: a 2-entry FIFO with push, pop, flush, full and empty signals and a 64-bit entry.
REQ-032 The top level SHALL hold only the PC, the FSM, the miss counter and control glue.

Verification
REQ-033 Release reset with hit=1 and stall=0 -> icache_addr steps 00400000, 00400004, 00400008; valid=1 from the first edge; instr_pc lags icache_addr by 4.
REQ-034 Hold hit=0 for 3 cycles at PC 00400040 -> PC holds, state=MISS, miss_cycles=3; the first hit pushes instr_pc=00400040.
REQ-035 Hold stall=1 with hit=1 -> after 2 edges the buffer is full and PC freezes at RESET_PC+8; releasing stall drains in order 00400000, then 00400004.
REQ-036 Assert branch_taken with target 0030e042 while the buffer is full and hit=1 -> next cycle valid=0, icache_addr=0030e040, and no old entries emerge.
REQ-037 Start with PC=FFFFFFFC via branch, then hit -> PC wraps to 00000000; drive reset=0 during a miss -> PC=00400000 and miss_cycles=0.
